scan_counter_display: RTL and testbench

SCAN_COUNTER_DISPLAY -- requirements
Module: scan_counter_display

---
 rtl/scan_counter_display.sv | 207 ++++++++++++++++++++
 tb/tb_scan_counter_display.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_counter_display.sv
// Purpose: hex/BCD up/down counter with a multiplexed 7-segment display scanner.
// Latency: count and tick change on the edge that ends the prescaler period; anodes/segments follow index/count by 1 cycle.
// Backpressure: none, free-running; run=0 freezes the count prescaler, the display scan never stops.
//
// Ports:
//   clk       rising-edge system clock
//   reset     asynchronous active-low reset
//   clear     synchronous clear of count and count prescaler (highest priority)
//   run       1 = count prescaler advances, 0 = hold
//   dir       1 = count up, 0 = count down
//   mode      0 = hex count, 1 = BCD count; any change clears the count
//   blank_lz  1 = suppress leading zero digits (digit 0 always shown)
//   count     registered count value, one nibble per digit
//   tick      one-cycle pulse in the cycle the count updated
//   segments  {g,f,e,d,c,b,a} active-low, registered
//   anodes    one-hot active-low digit enable, registered
module scan_counter_display #(
    parameter int DIGITS    = 8,
    parameter int COUNT_DIV = 25_000_000,
    parameter int SCAN_DIV  = 12_500
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  run,
    input  logic                  dir,
    input  logic                  mode,
    input  logic                  blank_lz,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick,
    output logic [6:0]            segments,
    output logic [DIGITS-1:0]     anodes
);

    // Counter widths; the max() guards keep every vector at least one bit wide
    // for the degenerate SCAN_DIV=1 and DIGITS=1 cases.
    localparam int CW = $clog2(COUNT_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0]       COUNT_LAST = CW'(COUNT_DIV - 1);
    localparam logic [SW-1:0]       SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]       IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [4*DIGITS-1:0] COUNT_ONE  = (4*DIGITS)'(1);

    // Active-low segment patterns {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // Count path
    // ------------------------------------------------------------------
    logic [CW-1:0]       count_presc;
    logic                mode_q;
    logic                mode_seen;
    logic                mode_chg;
    logic [4*DIGITS-1:0] hex_nxt;
    logic [4*DIGITS-1:0] bcd_nxt;
    logic [4*DIGITS-1:0] count_nxt;
    logic                bcd_carry;
    logic [3:0]          bcd_nib;

    // mode_seen stands in for "registered mode equals the input" while in
    // reset: the first edge after release only captures mode, so a value
    // held through reset is never treated as a change.
    assign mode_chg = mode_seen && (mode_q != mode);

    assign hex_nxt = dir ? (count + COUNT_ONE) : (count - COUNT_ONE);

    // Ripple decimal carry/borrow through the nibbles. Up: a 9 rolls to 0 and
    // carries on. Down: a 0 rolls to 9 and borrows on. All-9s and all-0s wrap
    // naturally because the carry simply falls off the top nibble.
    always_comb begin
        bcd_nxt   = count;
        bcd_carry = 1'b1;
        bcd_nib   = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd_nib = count[4*i +: 4];
            if (bcd_carry) begin
                if (dir) begin
                    if (bcd_nib >= 4'd9) begin
                        bcd_nxt[4*i +: 4] = 4'd0;
                    end else begin
                        bcd_nxt[4*i +: 4] = bcd_nib + 4'd1;
                        bcd_carry         = 1'b0;
                    end
                end else begin
                    if (bcd_nib == 4'd0) begin
                        bcd_nxt[4*i +: 4] = 4'd9;
                    end else begin
                        bcd_nxt[4*i +: 4] = bcd_nib - 4'd1;
                        bcd_carry         = 1'b0;
                    end
                end
            end
        end
    end

    // On a tick cycle mode_q equals mode, otherwise mode_chg would have won.
    assign count_nxt = mode_q ? bcd_nxt : hex_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count       <= '0;
            tick        <= 1'b0;
            count_presc <= '0;
            mode_q      <= 1'b0;
            mode_seen   <= 1'b0;
        end else begin
            mode_q    <= mode;
            mode_seen <= 1'b1;
            tick      <= 1'b0;
            if (clear || mode_chg) begin
                count       <= '0;
                count_presc <= '0;
            end else if (run) begin
                if (count_presc == COUNT_LAST) begin
                    count_presc <= '0;
                    tick        <= 1'b1;
                    count       <= count_nxt;
                end else begin
                    count_presc <= count_presc + CW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Display scan path
    // ------------------------------------------------------------------
    logic [SW-1:0]     scan_presc;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     msd;
    logic [3:0]        cur_nib;
    logic              digit_on;
    logic [DIGITS-1:0] anodes_nxt;

    // Position of the most significant nonzero nibble; 0 when count is zero
    // so digit 0 always stays lit under leading-zero blanking.
    always_comb begin
        msd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (count[4*i +: 4] != 4'd0) begin
                msd = IW'(i);
            end
        end
    end

    always_comb begin
        cur_nib = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib = count[4*i +: 4];
            end
        end
    end

    assign digit_on = !blank_lz || (idx <= msd);

    always_comb begin
        anodes_nxt = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_on && (idx == IW'(i))) begin
                anodes_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_presc <= '0;
            idx        <= '0;
            anodes     <= '1;
            segments   <= 7'h7F;
        end else begin
            anodes   <= anodes_nxt;
            segments <= seg_decode(cur_nib);
            if (scan_presc == SCAN_LAST) begin
                scan_presc <= '0;
                idx        <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                scan_presc <= scan_presc + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_scan_counter_display.sv
// Purpose: randomized and directed bench for scan_counter_display (DIGITS=4, COUNT_DIV=4, SCAN_DIV=2).
// Latency: reference model steps on each rising edge; monitor compares on the falling edge.
// Backpressure: none; expected tick counts are queued and popped whenever the DUT raises tick.
module tb_scan_counter_display;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        clear    = 1'b0;
    logic        run      = 1'b0;
    logic        dir      = 1'b1;
    logic        mode     = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] count;
    logic        tick;
    logic [6:0]  segments;
    logic [3:0]  anodes;

    always #5 clk = ~clk;

    scan_counter_display #(
        .DIGITS   (4),
        .COUNT_DIV(4),
        .SCAN_DIV (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .run     (run),
        .dir     (dir),
        .mode    (mode),
        .blank_lz(blank_lz),
        .count   (count),
        .tick    (tick),
        .segments(segments),
        .anodes  (anodes)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state: count held as an integer value.
    int         m_count = 0;
    int         m_presc = 0;
    int         m_sc    = 0;
    int         m_idx   = 0;
    bit         m_prev  = 1'b0;
    bit         m_shown;
    logic [3:0] exp_an  = 4'hF;
    logic [6:0] exp_seg = 7'h7F;
    int         exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Next count value by plain arithmetic: modulo 2^16 in hex, modulo 10000 in decimal.
    function automatic int next_count(int v, bit up, bit bcd);
        int d;
        if (!bcd) begin
            return up ? ((v + 1) & 32'hFFFF) : ((v + 65535) & 32'hFFFF);
        end
        d = ((v >> 12) & 15) * 1000 + ((v >> 8) & 15) * 100 + ((v >> 4) & 15) * 10 + (v & 15);
        d = up ? (d + 1) % 10000 : (d + 9999) % 10000;
        return ((d / 1000) << 12) | (((d / 100) % 10) << 8) | (((d / 10) % 10) << 4) | (d % 10);
    endfunction

    function automatic int top_digit(int v);
        int r = 0;
        for (int i = 0; i < 4; i++) begin
            if (((v >> (4 * i)) & 15) != 0) r = i;
        end
        return r;
    endfunction

    // Reference model: display expectations come from the pre-edge state,
    // then the count and scan position advance.
    always @(posedge clk) begin
        if (!reset) begin
            m_count = 0;
            m_presc = 0;
            m_sc    = 0;
            m_idx   = 0;
            m_prev  = mode;
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
            exp_q.delete();
        end else begin
            m_shown = !blank_lz || (m_idx <= top_digit(m_count));
            exp_an  = m_shown ? (4'hF & ~(4'b0001 << m_idx)) : 4'hF;
            exp_seg = seg_tab[(m_count >> (4 * m_idx)) & 15];
            if (clear || (mode != m_prev)) begin
                m_count = 0;
                m_presc = 0;
            end else if (run) begin
                if (m_presc == 3) begin
                    m_presc = 0;
                    m_count = next_count(m_count, dir, mode);
                    exp_q.push_back(m_count);
                end else begin
                    m_presc = m_presc + 1;
                end
            end
            m_prev = mode;
            if (m_sc == 1) begin
                m_sc  = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_sc = m_sc + 1;
            end
        end
    end

    // Monitor: compares outputs mid-cycle; tick pops the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            check("rst_count", count, 0);
            check("rst_tick", tick, 0);
            check("rst_anodes", anodes, 4'hF);
            check("rst_segments", segments, 7'h7F);
        end else begin
            check("count", count, m_count);
            check("anodes", anodes, exp_an);
            check("segments", segments, exp_seg);
            check("tick", tick, (exp_q.size() > 0) ? 1 : 0);
            if (tick && exp_q.size() > 0) begin
                check("tick_count", count, exp_q.pop_front());
            end
            exp_q.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input logic [15:0] target, input int bound);
        bit hit = 1'b0;
        run = 1'b1;
        for (int i = 0; i < bound; i++) begin
            step();
            if (m_count == int'(target)) begin
                hit = 1'b1;
                break;
            end
        end
        run = 1'b0;
        check($sformatf("reach_%04h", target), hit, 1);
        if (hit) check($sformatf("count_at_%04h", target), count, target);
    endtask

    initial begin
        logic [3:0] seen;

        // Reset held for a few cycles, then count up in hex.
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        run   = 1'b1;
        repeat (64) step();
        check("count_after_16_ticks", count, 16'h0010);

        // Scan of 1A3F without blanking.
        run_to(16'h1A3F, 30000);
        blank_lz = 1'b0;
        seen = 4'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            case (anodes)
                4'hE: check("scan_seg_d0", segments, 7'h0E);
                4'hD: check("scan_seg_d1", segments, 7'h30);
                4'hB: check("scan_seg_d2", segments, 7'h08);
                4'h7: check("scan_seg_d3", segments, 7'h79);
                default: check("scan_anodes_onehot", anodes, 4'hE);
            endcase
            seen = seen | ~anodes;
        end
        check("scan_all_digits", seen, 4'hF);

        // Hex wrap down and up.
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_count", count, 0);
        dir = 1'b0;
        run_to(16'hFFFF, 20);
        dir = 1'b1;
        run_to(16'h0000, 20);

        // BCD carries and wraps.
        mode = 1'b1;
        step();
        check("mode_set_count", count, 0);
        run_to(16'h0099, 500);
        run_to(16'h0100, 10);
        dir = 1'b0;
        run_to(16'h0000, 500);
        run_to(16'h9999, 10);
        dir = 1'b1;
        run_to(16'h0000, 10);

        // Mode toggle mid-count clears on the next edge.
        run_to(16'h0005, 40);
        mode = 1'b0;
        step();
        check("mode_toggle_count", count, 0);
        check("mode_toggle_tick", tick, 0);

        // Leading-zero blanking.
        run_to(16'h0003, 20);
        blank_lz = 1'b1;
        step();
        seen = 4'h0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("blank_only_digit0", (anodes == 4'hE || anodes == 4'hF), 1);
            seen = seen | ~anodes;
        end
        check("blank_digit0_lit", seen, 4'h1);
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        seen = 4'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (anodes == 4'hE) check("zero_digit0_seg", segments, 7'h40);
            seen = seen | ~anodes;
        end
        check("zero_digit0_lit", seen, 4'h1);
        blank_lz = 1'b0;

        // Clear on the tick cycle suppresses the tick.
        run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (m_presc == 3) break;
            step();
        end
        check("presc_at_last", m_presc, 3);
        clear = 1'b1;
        step();
        check("clear_tick_count", count, 0);
        check("clear_tick_tick", tick, 0);
        clear = 1'b0;

        // Asynchronous reset mid-scan.
        repeat (5) step();
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_anodes", anodes, 4'hF);
        check("async_rst_segments", segments, 7'h7F);
        check("async_rst_count", count, 0);
        check("async_rst_tick", tick, 0);
        step();
        step();
        reset = 1'b1;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            run      = ($urandom % 5) != 0;
            dir      = $urandom % 2;
            clear    = ($urandom % 40) == 0;
            blank_lz = ($urandom % 4) == 0;
            if (($urandom % 60) == 0) mode = ~mode;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
